// File: rtl/alm_pkg.sv
// Shared definitions for the ALM multiplier datapath: log-format width and
// field-slicing constants used by the encoder, the multiplication unit and their benches.
package alm_pkg;

  function automatic int LOGW(input int bw);
    return $clog2(bw) + bw - 1;
  endfunction

  localparam int ALM_BW   = 32;
  localparam int K_MSB    = LOGW(ALM_BW) - 1;
  localparam int FRAC_MSB = ALM_BW - 2;

endpackage

// File: rtl/alm_lod_encoder.sv
// Combinational leading-one detector and priority encoder: k = index of the
// most significant set bit, zero = operand is all zeros (k reads 0 then).
module alm_lod_encoder
  import alm_pkg::*;
#(
  parameter int BW         = ALM_BW,
  parameter int LOG2_WIDTH = $clog2(BW)
) (
  input  logic [BW-1:0]         operand,
  output logic [LOG2_WIDTH-1:0] k,
  output logic                  zero
);

  // Ascending scan: the last set bit seen is the most significant one.
  always_comb begin
    k = '0;
    for (int unsigned i = 0; i < BW; i++) begin
      if (operand[i]) k = LOG2_WIDTH'(i);
    end
  end

  assign zero = (operand == '0);

endmodule

// File: rtl/alm_log_encoder.sv
// Two-stage pipelined binary-to-log encoder with valid/ready flow control.
// Output is {k, fraction}, fraction being the bits below the leading one, left-aligned.
module alm_log_encoder
  import alm_pkg::*;
#(
  parameter int BW         = ALM_BW,
  parameter int LOG2_WIDTH = $clog2(BW)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BW-1:0]                operand,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LOG2_WIDTH+BW-2:0]     log_concat_format,
  output logic                         zero_flag
);

  logic                  r_s1_valid;
  logic [BW-2:0]         r_s1_operand;
  logic [LOG2_WIDTH-1:0] r_s1_k;
  logic                  r_s1_z;

  logic                  r_s2_valid;
  logic [LOG2_WIDTH-1:0] r_s2_k;
  logic [BW-2:0]         r_s2_frac;
  logic                  r_s2_z;

  logic                  w_s1_adv;
  logic                  w_s2_adv;
  logic [LOG2_WIDTH-1:0] w_k;
  logic                  w_z;
  logic [LOG2_WIDTH-1:0] w_shamt;
  logic [BW-2:0]         w_frac;

  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  alm_lod_encoder #(
    .BW         (BW),
    .LOG2_WIDTH (LOG2_WIDTH)
  ) u_lod (
    .operand (operand),
    .k       (w_k),
    .zero    (w_z)
  );

  // The leading one itself is never stored: shifting the lower BW-1 bits by
  // BW-1-k pushes it out of the top, leaving the left-aligned fraction.
  assign w_shamt = LOG2_WIDTH'(BW - 1) - r_s1_k;
  assign w_frac  = r_s1_operand << w_shamt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_operand <= '0;
      r_s1_k       <= '0;
      r_s1_z       <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_operand <= operand[BW-2:0];
        r_s1_k       <= w_k;
        r_s1_z       <= w_z;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_k     <= '0;
      r_s2_frac  <= '0;
      r_s2_z     <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_k    <= r_s1_k;
        r_s2_frac <= w_frac;
        r_s2_z    <= r_s1_z;
      end
    end
  end

  assign out_valid         = r_s2_valid;
  assign log_concat_format = {r_s2_k, r_s2_frac};
  assign zero_flag         = r_s2_z;

endmodule

// File: tb/tb_alm_log_encoder.sv
// Self-checking bench for alm_log_encoder at BW=8: directed table, backpressure,
// mid-stream reset, back-to-back throughput and random valid/ready traffic.
module tb_alm_log_encoder;
  import alm_pkg::*;

  localparam int BW = 8;
  localparam int LW = LOGW(BW);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] operand = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [LW-1:0] log_concat_format;
  logic          zero_flag;

  alm_log_encoder #(.BW(BW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .operand           (operand),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .log_concat_format (log_concat_format),
    .zero_flag         (zero_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] op;
    logic [LW-1:0] lcf;
    logic          z;
  } vec_t;

  typedef struct {
    logic [LW-1:0] lcf;
    logic          z;
    int            cyc;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   exact_lat = 1'b0;
  exp_t sb[$];
  logic [LW:0] got[$];
  bit   prev_stall = 1'b0;
  logic [LW-1:0] prev_lcf;
  logic          prev_z;

  vec_t tab[7];
  logic [BW-1:0] bp_ops[5];

  // Reference: k = floor(log2 x), fraction = (x - 2^k) << (BW-1-k).
  function automatic logic [LW:0] ref_enc(input int unsigned x);
    int unsigned k;
    int unsigned frac;
    if (x == 0) return {1'b1, {LW{1'b0}}};
    k = 0;
    while ((x >> (k + 1)) != 0) k++;
    frac = (x - (32'd1 << k)) << (BW - 1 - k);
    return {1'b0, LW'(k * (1 << (BW - 1)) + frac)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    exp_t e;
    logic [LW:0] r;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        sb.delete();
        prev_stall = 1'b0;
        continue;
      end
      chk("in_ready_rule", 32'(in_ready), 32'((sb.size() < 2) || out_ready));
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_lcf", 32'(log_concat_format), 32'(prev_lcf));
        chk("hold_zero", 32'(zero_flag), 32'(prev_z));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("lcf", 32'(log_concat_format), 32'(e.lcf));
          chk("zero_flag", 32'(zero_flag), 32'(e.z));
          if (exact_lat) chk("latency", 32'(cyc - e.cyc), 32'd2);
          else chk("latency_min", 32'((cyc - e.cyc) >= 2), 32'd1);
          got.push_back({zero_flag, log_concat_format});
        end
      end
      if (in_valid && in_ready) begin
        r = ref_enc(int'(operand));
        e.lcf = r[LW-1:0];
        e.z   = r[LW];
        e.cyc = cyc;
        sb.push_back(e);
      end
      prev_stall = out_valid && !out_ready;
      prev_lcf   = log_concat_format;
      prev_z     = zero_flag;
    end
  endtask

  task automatic drain(input string name);
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      step();
      n++;
    end
    step();
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int idx;
    int n;
    tab[0] = '{8'd6,   10'h140, 1'b0};
    tab[1] = '{8'hFF,  10'h3FF, 1'b0};
    tab[2] = '{8'h80,  10'h380, 1'b0};
    tab[3] = '{8'd1,   10'h000, 1'b0};
    tab[4] = '{8'd0,   10'h000, 1'b1};
    tab[5] = '{8'd3,   10'h0C0, 1'b0};
    tab[6] = '{8'h7F,  10'h37E, 1'b0};
    bp_ops = '{8'd3, 8'hFF, 8'h80, 8'd1, 8'd0};

    fork
      monitor();
    join_none

    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_lcf", 32'(log_concat_format), 32'd0);
    chk("rst_zero", 32'(zero_flag), 32'd0);
    rst_n = 1'b1;
    step();

    // Directed table, no stalls: exact 2-cycle latency in order
    exact_lat = 1'b1;
    out_ready = 1'b1;
    got.delete();
    foreach (tab[i]) begin
      in_valid = 1'b1;
      operand  = tab[i].op;
      step();
    end
    drain("table_drain");
    chk("table_count", 32'(got.size()), 32'(7));
    foreach (tab[i]) begin
      if (i < got.size()) begin
        chk("table_lcf", 32'(got[i][LW-1:0]), 32'(tab[i].lcf));
        chk("table_zero", 32'(got[i][LW]), 32'(tab[i].z));
      end
    end
    exact_lat = 1'b0;

    // Backpressure: out_ready low for 5 cycles
    got.delete();
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      operand  = bp_ops[idx];
      @(negedge clk);
      if (in_ready) idx++;
      step();
    end
    chk("bp_accepts", 32'(idx), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_lcf", 32'(log_concat_format), 32'h0C0);
    out_ready = 1'b1;
    n = 0;
    while (idx < 5 && n < 20) begin
      in_valid = 1'b1;
      operand  = bp_ops[idx];
      @(negedge clk);
      if (in_ready) idx++;
      step();
      n++;
    end
    chk("bp_all_accepted", 32'(idx), 32'd5);
    drain("bp_drain");
    chk("bp_count", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < got.size()) chk("bp_order", 32'(got[i]), 32'(ref_enc(int'(bp_ops[i]))));
    end

    // Reset mid-stream with both stages full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      operand = 8'($urandom);
      step();
    end
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_lcf", 32'(log_concat_format), 32'd0);
    out_ready = 1'b1;
    step();
    step();
    #2;
    rst_n = 1'b1;
    step();
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("no_stale_out", 32'(out_valid), 32'd0);
    end

    // Throughput: 64 back-to-back random operands
    exact_lat = 1'b1;
    got.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1;
      operand  = 8'($urandom);
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    chk("tput_count", 32'(got.size()), 32'd64);
    drain("tput_drain");
    exact_lat = 1'b0;

    // Random valid/ready traffic
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 55);
      case ($urandom_range(0, 7))
        0: operand = 8'd0;
        1: operand = 8'd1;
        default: operand = 8'($urandom);
      endcase
      step();
    end
    drain("rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
